// File: rtl/wbtl_stage.sv
// Write-back / long-write / memory stage: retires ALU ops, two-write long ops
// and loads/stores through a request/ack memory port with a timeout.
module wbtl_stage #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs_data_in,
  input  logic [4:0]  rd_in,
  input  logic [4:0]  rs_in,
  input  logic        mem_write_in,
  input  logic        alu_reg_write_in,
  input  logic        mem_reg_write_in,
  input  logic        long_write_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic [31:0] retire_count,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_LONG2    = 2'd2
  } state_e;

  localparam logic [31:0] TMO_LAST = 32'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rsd_q, rsd_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs_q, rs_d;
  logic        store_q, store_d;
  logic [31:0] tmo_q, tmo_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        retire_q, retire_d;
  logic [31:0] retire_pc_q, retire_pc_d;
  logic [31:0] retire_count_q, retire_count_d;
  logic        mem_err_q, mem_err_d;

  logic dec_store, dec_load, dec_alu;

  // Priority decode: store beats load beats ALU; long_write only qualifies ALU.
  assign dec_store = mem_write_in;
  assign dec_load  = !mem_write_in && mem_reg_write_in;
  assign dec_alu   = !mem_write_in && !mem_reg_write_in && alu_reg_write_in;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    rsd_d       = rsd_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    store_d     = store_q;
    tmo_d       = tmo_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = '0;
    rf_wdata_d  = '0;
    retire_d    = 1'b0;
    retire_pc_d = retire_pc_q;
    mem_err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        pc_d    = pc_in;
        addr_d  = alu_result_in;
        rsd_d   = rs_data_in;
        rd_d    = rd_in;
        rs_d    = rs_in;
        store_d = dec_store;
        if (dec_store || dec_load) begin
          state_d = S_MEM_WAIT;
          tmo_d   = '0;
        end else if (dec_alu) begin
          rf_we_d    = (rd_in != 5'd0);
          rf_waddr_d = rd_in;
          rf_wdata_d = alu_result_in;
          if (long_write_in) begin
            state_d = S_LONG2;
          end else begin
            retire_d    = 1'b1;
            retire_pc_d = pc_in;
          end
        end
      end
      S_MEM_WAIT: begin
        // An ack on the final timeout cycle still completes the access.
        if (mem_ack) begin
          state_d     = S_IDLE;
          retire_d    = 1'b1;
          retire_pc_d = pc_q;
          if (!store_q) begin
            rf_we_d    = (rd_q != 5'd0);
            rf_waddr_d = rd_q;
            rf_wdata_d = mem_rdata;
          end
        end else if (tmo_q >= TMO_LAST) begin
          state_d   = S_IDLE;
          mem_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_LONG2: begin
        state_d     = S_IDLE;
        rf_we_d     = (rs_q != 5'd0);
        rf_waddr_d  = rs_q;
        rf_wdata_d  = rsd_q;
        retire_d    = 1'b1;
        retire_pc_d = pc_q;
      end
      default: state_d = S_IDLE;
    endcase

    retire_count_d = retire_count_q + {31'd0, retire_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      addr_q         <= '0;
      rsd_q          <= '0;
      rd_q           <= '0;
      rs_q           <= '0;
      store_q        <= 1'b0;
      tmo_q          <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      retire_q       <= 1'b0;
      retire_pc_q    <= '0;
      retire_count_q <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      addr_q         <= addr_d;
      rsd_q          <= rsd_d;
      rd_q           <= rd_d;
      rs_q           <= rs_d;
      store_q        <= store_d;
      tmo_q          <= tmo_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      retire_q       <= retire_d;
      retire_pc_q    <= retire_pc_d;
      retire_count_q <= retire_count_d;
      mem_err_q      <= mem_err_d;
    end
  end

  assign stall        = (state_q != S_IDLE);
  assign mem_req      = (state_q == S_MEM_WAIT);
  assign mem_we       = mem_req && store_q;
  assign mem_addr     = mem_req ? addr_q : '0;
  assign mem_wdata    = (mem_req && store_q) ? rsd_q : '0;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign retire       = retire_q;
  assign retire_pc    = retire_pc_q;
  assign retire_count = retire_count_q;
  assign mem_err      = mem_err_q;

endmodule

// File: tb/tb_wbtl_stage.sv
// Directed bench for wbtl_stage: ALU, long, load, store-timeout, r0, wrap, reset.
module tb_wbtl_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, alu_result_in, rs_data_in;
  logic [4:0]  rd_in, rs_in;
  logic        mem_write_in, alu_reg_write_in, mem_reg_write_in, long_write_in;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire;
  logic [31:0] retire_pc, retire_count;
  logic        mem_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] exp_count = '0;

  always #5 clk = ~clk;

  wbtl_stage #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .pc_in(pc_in), .alu_result_in(alu_result_in), .rs_data_in(rs_data_in),
    .rd_in(rd_in), .rs_in(rs_in),
    .mem_write_in(mem_write_in), .alu_reg_write_in(alu_reg_write_in),
    .mem_reg_write_in(mem_reg_write_in), .long_write_in(long_write_in),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire(retire), .retire_pc(retire_pc), .retire_count(retire_count),
    .mem_err(mem_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble;
    mem_write_in = 0; alu_reg_write_in = 0; mem_reg_write_in = 0; long_write_in = 0;
  endtask

  task automatic test_reset;
    reset = 1; bubble(); mem_ack = 0; mem_rdata = '0;
    pc_in = '0; alu_result_in = '0; rs_data_in = '0; rd_in = '0; rs_in = '0;
    #2 reset = 0;
    #1;
    n_cmp++; if ({stall, mem_req, rf_we, retire, mem_err} !== 5'b0) begin n_bad++; $display("FAIL reset_ctl: got %b expected 00000", {stall, mem_req, rf_we, retire, mem_err}); end
    n_cmp++; if (retire_count !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %h expected 0", retire_count); end
    alu_result_in = 32'h77; rd_in = 5'd3; alu_reg_write_in = 1;
    tick();
    n_cmp++; if (rf_we !== 1'b0 || retire !== 1'b0) begin n_bad++; $display("FAIL reset_hold: got we=%b ret=%b expected 0 0", rf_we, retire); end
    bubble();
    reset = 1;
  endtask

  task automatic test_alu;
    pc_in = 32'h40; rd_in = 5'd5; alu_result_in = 32'h1234; alu_reg_write_in = 1;
    tick(); exp_count++;
    n_cmp++; if ({rf_we, retire, stall} !== 3'b110) begin n_bad++; $display("FAIL alu_ctl: got %b expected 110", {rf_we, retire, stall}); end
    n_cmp++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin n_bad++; $display("FAIL alu_wr: got %0d/%h expected 5/1234", rf_waddr, rf_wdata); end
    n_cmp++; if (retire_pc !== 32'h40 || retire_count !== exp_count) begin n_bad++; $display("FAIL alu_ret: got pc=%h cnt=%0d expected 40/%0d", retire_pc, retire_count, exp_count); end
    bubble();
    tick();
    n_cmp++; if (rf_we !== 1'b0 || retire !== 1'b0) begin n_bad++; $display("FAIL alu_pulse: got we=%b ret=%b expected 0 0", rf_we, retire); end
  endtask

  task automatic test_load;
    pc_in = 32'h44; rd_in = 5'd7; alu_result_in = 32'h100; mem_reg_write_in = 1; alu_reg_write_in = 1;
    tick();
    // upstream garbage while stalled must be ignored
    mem_reg_write_in = 0; pc_in = 32'h999; rd_in = 5'd9; alu_result_in = 32'hFFFF;
    for (int i = 1; i <= 3; i++) begin
      n_cmp++; if ({mem_req, mem_we, stall} !== 3'b101 || mem_addr !== 32'h100) begin n_bad++; $display("FAIL load_req%0d: got req/we/stall=%b addr=%h expected 101/100", i, {mem_req, mem_we, stall}, mem_addr); end
      if (i == 3) begin mem_ack = 1; mem_rdata = 32'hDEADBEEF; end
      if (i == 3) bubble();
      tick();
    end
    mem_ack = 0; mem_rdata = 32'h0; exp_count++;
    n_cmp++; if ({mem_req, stall, rf_we, retire} !== 4'b0011) begin n_bad++; $display("FAIL load_done: got %b expected 0011", {mem_req, stall, rf_we, retire}); end
    n_cmp++; if (rf_waddr !== 5'd7 || rf_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_wr: got %0d/%h expected 7/deadbeef", rf_waddr, rf_wdata); end
    n_cmp++; if (retire_pc !== 32'h44 || retire_count !== exp_count) begin n_bad++; $display("FAIL load_ret: got pc=%h cnt=%0d expected 44/%0d", retire_pc, retire_count, exp_count); end
    tick();
  endtask

  task automatic test_long;
    pc_in = 32'h48; rd_in = 5'd2; rs_in = 5'd3; alu_result_in = 32'hA; rs_data_in = 32'hB;
    alu_reg_write_in = 1; long_write_in = 1;
    tick();
    bubble();
    n_cmp++; if ({rf_we, retire, stall} !== 3'b101 || rf_waddr !== 5'd2 || rf_wdata !== 32'hA) begin n_bad++; $display("FAIL long_w1: got %b %0d %h expected 101 2 a", {rf_we, retire, stall}, rf_waddr, rf_wdata); end
    tick(); exp_count++;
    n_cmp++; if ({rf_we, retire, stall} !== 3'b110 || rf_waddr !== 5'd3 || rf_wdata !== 32'hB) begin n_bad++; $display("FAIL long_w2: got %b %0d %h expected 110 3 b", {rf_we, retire, stall}, rf_waddr, rf_wdata); end
    n_cmp++; if (retire_count !== exp_count || retire_pc !== 32'h48) begin n_bad++; $display("FAIL long_ret: got cnt=%0d pc=%h expected %0d/48", retire_count, retire_pc, exp_count); end
    tick();
    n_cmp++; if (rf_we !== 1'b0 || retire !== 1'b0) begin n_bad++; $display("FAIL long_end: got we=%b ret=%b expected 0 0", rf_we, retire); end
  endtask

  task automatic test_store_timeout;
    pc_in = 32'h4C; alu_result_in = 32'h200; rs_data_in = 32'h55; rd_in = 5'd8;
    mem_write_in = 1; mem_reg_write_in = 1;
    tick();
    bubble();
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if ({mem_req, mem_we, mem_err} !== 3'b110 || mem_wdata !== 32'h55 || mem_addr !== 32'h200) begin n_bad++; $display("FAIL st_req%0d: got %b addr=%h wd=%h expected 110/200/55", i, {mem_req, mem_we, mem_err}, mem_addr, mem_wdata); end
      tick();
    end
    n_cmp++; if ({mem_req, stall, mem_err, retire, rf_we} !== 5'b00100) begin n_bad++; $display("FAIL st_tmo: got %b expected 00100", {mem_req, stall, mem_err, retire, rf_we}); end
    n_cmp++; if (retire_count !== exp_count) begin n_bad++; $display("FAIL st_cnt: got %0d expected %0d", retire_count, exp_count); end
    tick();
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL st_errpulse: got %b expected 0", mem_err); end
  endtask

  task automatic test_rd0;
    pc_in = 32'h50; rd_in = 5'd0; alu_result_in = 32'hCAFE; alu_reg_write_in = 1;
    tick(); exp_count++;
    bubble();
    n_cmp++; if ({rf_we, retire} !== 2'b01 || retire_count !== exp_count) begin n_bad++; $display("FAIL rd0: got we/ret=%b cnt=%0d expected 01/%0d", {rf_we, retire}, retire_count, exp_count); end
    tick();
  endtask

  task automatic test_back_to_back;
    pc_in = 32'h60; rd_in = 5'd4; alu_result_in = 32'h1; alu_reg_write_in = 1;
    tick(); exp_count++;
    pc_in = 32'h64; rd_in = 5'd6; alu_result_in = 32'h2;
    n_cmp++; if (rf_waddr !== 5'd4 || rf_wdata !== 32'h1 || retire !== 1'b1) begin n_bad++; $display("FAIL b2b_1: got %0d/%h/%b expected 4/1/1", rf_waddr, rf_wdata, retire); end
    tick(); exp_count++;
    n_cmp++; if (rf_waddr !== 5'd6 || rf_wdata !== 32'h2 || retire_pc !== 32'h64 || retire_count !== exp_count) begin n_bad++; $display("FAIL b2b_2: got %0d/%h pc=%h cnt=%0d expected 6/2/64/%0d", rf_waddr, rf_wdata, retire_pc, retire_count, exp_count); end
    // long op whose second destination is r0
    pc_in = 32'h68; rd_in = 5'd1; rs_in = 5'd0; alu_result_in = 32'h3; rs_data_in = 32'h4; long_write_in = 1;
    tick();
    bubble();
    tick(); exp_count++;
    n_cmp++; if ({rf_we, retire} !== 2'b01 || retire_count !== exp_count) begin n_bad++; $display("FAIL long_r0: got we/ret=%b cnt=%0d expected 01/%0d", {rf_we, retire}, retire_count, exp_count); end
    tick();
  endtask

  task automatic test_wrap;
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1 release dut.retire_count_q;
    #1;
    pc_in = 32'h70; rd_in = 5'd1; alu_result_in = 32'h9; alu_reg_write_in = 1;
    tick();
    bubble();
    exp_count = 32'd0;
    n_cmp++; if (retire_count !== exp_count || retire !== 1'b1) begin n_bad++; $display("FAIL wrap: got cnt=%h ret=%b expected 0/1", retire_count, retire); end
    tick();
  endtask

  task automatic test_reset_mid;
    pc_in = 32'h80; rd_in = 5'd7; alu_result_in = 32'h300; mem_reg_write_in = 1;
    tick();
    bubble();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_pre: got req=%b expected 1", mem_req); end
    #2 reset = 0;
    #1;
    n_cmp++; if ({mem_req, stall, mem_we, rf_we, retire, mem_err} !== 6'b0 || mem_addr !== 32'h0 || retire_count !== 32'h0) begin n_bad++; $display("FAIL rst_mid: got %b addr=%h cnt=%h expected 000000/0/0", {mem_req, stall, mem_we, rf_we, retire, mem_err}, mem_addr, retire_count); end
    #2 reset = 1;
    tick();
    n_cmp++; if ({mem_req, stall} !== 2'b00) begin n_bad++; $display("FAIL rst_after: got %b expected 00", {mem_req, stall}); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_long();
    test_store_timeout();
    test_rd0();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wbtl_stage.md
WBTL_STAGE -- requirements
Module: wbtl_stage

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: max cycles in MEM_WAIT without mem_ack before the access is abandoned.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 pc_in, alu_result_in, rs_data_in  in  32 each  EX_WBTL outputs: pc, ALU result/address, store data / second long-write value.
REQ-005 rd_in, rs_in  in  5 each  destination register, second long-write destination.
REQ-006 mem_write_in, alu_reg_write_in, mem_reg_write_in, long_write_in  in  1 each  control bits from EX_WBTL; all-zero = bubble.
REQ-007 stall  out  1  drives upstream we low (EX_WBTL we = !stall).
REQ-008 mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32 each; mem_ack  in  1; mem_rdata  in  32.
REQ-009 rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32  register-file write port.
REQ-010 retire  out  1; retire_pc  out  32; retire_count  out  32; mem_err  out  1.

Function
REQ-011 States: IDLE, MEM_WAIT, LONG2; stall SHALL equal (state != IDLE), combinational.
REQ-012 In IDLE, inputs SHALL be sampled every cycle and latched internally; a bubble causes no action.
REQ-013 Op decode priority: mem_write > mem_reg_write > alu_reg_write; lower-priority bits ignored.
REQ-014 long_write SHALL only qualify alu_reg_write; ignored with mem ops.
REQ-015 ALU op (no long_write) accepted at edge N: rf_we=1, rf_waddr=rd, rf_wdata=alu_result, retire=1 during cycle N+1; state stays IDLE.
REQ-016 Long ALU op accepted at N: cycle N+1 writes rd<=alu_result, state LONG2; cycle N+2 writes rs<=rs_data, retire=1, state IDLE.
REQ-017 Store/load accepted at N: state MEM_WAIT from N+1; mem_req=1, mem_addr=alu_result, mem_we=1 for store else 0, mem_wdata=rs_data (store), all held stable until mem_ack.
REQ-018 mem_ack SHALL only be honoured while mem_req=1; ack sampled at an edge SHALL drop mem_req in the next cycle and return to IDLE.
REQ-019 Load: mem_rdata captured at the ack edge; rf write rd<=mem_rdata with retire=1 in the following cycle.
REQ-020 Store: retire=1 in the cycle after the ack edge; no rf write.
REQ-021 Any rf write targeting register 0 SHALL be suppressed (rf_we=0); the cycle and retire still occur.
REQ-022 Timeout counter clears on MEM_WAIT entry; after MEM_TIMEOUT cycles without ack: mem_req drops, mem_err=1 one cycle, no rf write, no retire, state IDLE.
REQ-023 rf_we, retire, mem_err SHALL be single-cycle pulses per event; retire_pc = latched pc of the retiring op.
REQ-024 retire_count increments by 1 per retire pulse, wraps 0xFFFFFFFF -> 0.
REQ-025 Upstream inputs changing while stall=1 SHALL have no effect (latched copy used).

Reset
REQ-026 reset=0 SHALL immediately force state IDLE and all outputs/counters to 0, including mid-MEM_WAIT (mem_req drops asynchronously) and mid-LONG2 (second write lost).
REQ-027 After reset release, first op accepted on the first clk edge with reset=1.

Verification
REQ-028 ALU op rd=5, alu_result=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234, retire=1, stall=0.
REQ-029 Load addr=0x100, ack after 3 req cycles, rdata=0xDEADBEEF, rd=7 -> mem_req high 3 cycles, stall high, then rf write r7=0xDEADBEEF, retire_count+1.
REQ-030 Long op rd=2, rs=3, alu=0xA, rs_data=0xB -> consecutive writes r2=0xA, r3=0xB, one retire, stall high one cycle.
REQ-031 Store with MEM_TIMEOUT=4, no ack -> mem_req 4 cycles, mem_err pulse, no retire, IDLE.
REQ-032 ALU op rd=0 -> rf_we=0, retire=1; reset=0 mid-MEM_WAIT -> mem_req=0 same cycle, all outputs 0.
REQ-033 retire_count preset via 0xFFFFFFFF retires (or forced) plus one retire -> 0.
